// File: rtl/wght_upd_pkg.sv
// ----------------------------------------------------------------------------
// wght_upd_pkg
// Shared definitions for the weight update stage:
//   - default number of fractional bits of the weight format
//   - state encoding of the update controller (ACC, APPLY, DONE)
//   - helpers returning the signed max/min of a WIDTH-bit two's complement word
// ----------------------------------------------------------------------------
package wght_upd_pkg;

    localparam int FRAC_DEFAULT = 24;

    // Controller states, kept as plain constants for tools that lack enums
    localparam logic [1:0] ST_ACC   = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Results are returned in 64 bits; callers keep the low w bits.
    // This works for any w up to 64.
    function automatic logic [63:0] signedMax(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] signedMin(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/wght_upd_sat_sub.sv
// ----------------------------------------------------------------------------
// sat_sub
// Combinational WIDTH-bit signed saturating subtractor: o_y = sat(i_a - i_b).
// Ports:
//   i_a   minuend (signed)
//   i_b   subtrahend (signed)
//   o_y   difference, clamped to the signed WIDTH-bit range
//   o_sat high when clamping took place
// ----------------------------------------------------------------------------
module sat_sub
    import wght_upd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y,
    output logic             o_sat
);

    localparam logic [63:0] MAX64 = signedMax(WIDTH);
    localparam logic [63:0] MIN64 = signedMin(WIDTH);

    logic [WIDTH-1:0] w_max;
    logic [WIDTH-1:0] w_min;
    logic [WIDTH:0]   w_diff;

    assign w_max = MAX64[WIDTH-1:0];
    assign w_min = MIN64[WIDTH-1:0];

    // One guard bit is enough to hold any difference of two WIDTH-bit values
    assign w_diff = {i_a[WIDTH-1], i_a} - {i_b[WIDTH-1], i_b};

    // Overflow when the guard bit disagrees with the WIDTH-bit sign; the
    // guard bit then carries the true sign and picks the clamp direction.
    assign o_sat = w_diff[WIDTH] ^ w_diff[WIDTH-1];
    assign o_y   = !o_sat ? w_diff[WIDTH-1:0]
                 : (w_diff[WIDTH] ? w_min : w_max);

endmodule

// File: rtl/wght_upd.sv
// ----------------------------------------------------------------------------
// wght_upd
// Weight update stage behind the weight accumulator. Counts 2^LOG2_BATCH
// accumulated samples, then in a single APPLY cycle computes
//   w <= sat(w - (acc >>> LOG2_BATCH))
// clears the accumulator on the same edge and pulses o_done one cycle later.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   i_smp      one sample accumulated (pulse, ignored while busy)
//   i_acc      accumulator sum, valid during APPLY
//   i_ld       load i_w_init into the weight (ignored while busy)
//   i_w_init   initial weight value
//   o_w        current weight (registered)
//   o_acc_clr  accumulator clear, high during APPLY
//   o_busy     high during APPLY and DONE
//   o_done     one-cycle pulse, new weight visible on o_w
//   o_sat      sticky saturation flag, cleared only by reset
// ----------------------------------------------------------------------------
module wght_upd
    import wght_upd_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FRAC       = FRAC_DEFAULT,
    parameter int LOG2_BATCH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_smp,
    input  logic [WIDTH-1:0] i_acc,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_w_init,
    output logic [WIDTH-1:0] o_w,
    output logic             o_acc_clr,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_sat
);

    // The fixed-point format only matters for interpretation, but it must fit
    if (FRAC < 0 || FRAC >= WIDTH) begin : g_badFrac
        $error("wght_upd: FRAC must lie in [0, WIDTH-1]");
    end

    // A zero-width counter is not legal, so per-sample mode keeps one bit
    // that simply stays at zero.
    localparam int             CNT_W    = (LOG2_BATCH > 0) ? LOG2_BATCH : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_BATCH) - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_w;
    logic             r_sat;

    logic signed [WIDTH-1:0] w_accS;
    logic [WIDTH-1:0]        w_scaled;
    logic [WIDTH-1:0]        w_newW;
    logic                    w_subSat;

    // Arithmetic shift divides by the batch size, rounding toward -inf
    assign w_accS   = i_acc;
    assign w_scaled = w_accS >>> LOG2_BATCH;

    sat_sub #(
        .WIDTH (WIDTH)
    ) u_satSub (
        .i_a   (r_w),
        .i_b   (w_scaled),
        .o_y   (w_newW),
        .o_sat (w_subSat)
    );

    // Sample counter, weight register and controller. Loads and samples are
    // only accepted in ACC, which is what makes them ignored while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
            r_cnt   <= '0;
            r_w     <= '0;
            r_sat   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (i_ld) begin
                        r_w   <= i_w_init;
                        r_cnt <= '0;
                    end else if (i_smp) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt   <= '0;
                            r_state <= ST_APPLY;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_APPLY: begin
                    r_w <= w_newW;
                    if (w_subSat) begin
                        r_sat <= 1'b1;
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_ACC;
                end
                default: begin
                    r_state <= ST_ACC;
                end
            endcase
        end
    end

    // Strobes are decoded from the registered state, so the accumulator clear
    // lines up with the edge that writes the weight.
    assign o_acc_clr = (r_state == ST_APPLY);
    assign o_done    = (r_state == ST_DONE);
    assign o_busy    = (r_state == ST_APPLY) || (r_state == ST_DONE);
    assign o_w       = r_w;
    assign o_sat     = r_sat;

endmodule

// File: tb/tb_wght_upd.sv
// ----------------------------------------------------------------------------
// tb_wght_upd
// Directed bench for wght_upd: one instance with batch size 4 and one in
// per-sample mode. Expected weights are hand-computed Q8.24 values.
// ----------------------------------------------------------------------------
module tb_wght_upd;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_smp;
    logic [31:0] i_acc;
    logic        i_ld;
    logic [31:0] i_w_init;
    logic [31:0] o_w;
    logic        o_acc_clr;
    logic        o_busy;
    logic        o_done;
    logic        o_sat;

    logic        pSmp;
    logic [31:0] pAcc;
    logic        pLd;
    logic [31:0] pWInit;
    logic [31:0] pW;
    logic        pAccClr;
    logic        pBusy;
    logic        pDone;
    logic        pSat;

    int compCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    wght_upd #(
        .WIDTH      (32),
        .FRAC       (24),
        .LOG2_BATCH (2)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .i_smp     (i_smp),
        .i_acc     (i_acc),
        .i_ld      (i_ld),
        .i_w_init  (i_w_init),
        .o_w       (o_w),
        .o_acc_clr (o_acc_clr),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_sat     (o_sat)
    );

    wght_upd #(
        .WIDTH      (32),
        .FRAC       (24),
        .LOG2_BATCH (0)
    ) u_dutPs (
        .clk       (clk),
        .rst       (rst),
        .i_smp     (pSmp),
        .i_acc     (pAcc),
        .i_ld      (pLd),
        .i_w_init  (pWInit),
        .o_w       (pW),
        .o_acc_clr (pAccClr),
        .o_busy    (pBusy),
        .o_done    (pDone),
        .o_sat     (pSat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] act,
                               input logic [31:0] exp);
        compCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Drive all main-DUT inputs for one cycle, then step past the edge
    task automatic applyStimulus(input logic ld, input logic smp,
                                 input logic [31:0] wInit, input logic [31:0] acc);
        i_ld     = ld;
        i_smp    = smp;
        i_w_init = wInit;
        i_acc    = acc;
        tick();
    endtask

    // Four sample pulses followed by APPLY and DONE. With holdSmp set, i_smp
    // and a stray load are also driven while busy and must be ignored.
    task automatic doBatch(input string tag, input logic [31:0] oldW,
                           input logic [31:0] accVal, input logic [31:0] expW,
                           input logic expSat, input logic holdSmp);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
        checkOutput({tag, ".busyEarly"}, {31'b0, o_busy}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
        checkOutput({tag, ".applyClr"},  {31'b0, o_acc_clr}, 32'd1);
        checkOutput({tag, ".applyBusy"}, {31'b0, o_busy}, 32'd1);
        checkOutput({tag, ".applyDone"}, {31'b0, o_done}, 32'd0);
        checkOutput({tag, ".applyOldW"}, o_w, oldW);
        applyStimulus(1'b0, holdSmp, 32'h0, accVal);
        checkOutput({tag, ".done"},    {31'b0, o_done}, 32'd1);
        checkOutput({tag, ".newW"},    o_w, expW);
        checkOutput({tag, ".sat"},     {31'b0, o_sat}, {31'b0, expSat});
        checkOutput({tag, ".doneClr"}, {31'b0, o_acc_clr}, 32'd0);
        applyStimulus(holdSmp, holdSmp, 32'hDEAD_BEEF, 32'h0);
        checkOutput({tag, ".idleDone"}, {31'b0, o_done}, 32'd0);
        checkOutput({tag, ".idleBusy"}, {31'b0, o_busy}, 32'd0);
        checkOutput({tag, ".idleW"},    o_w, expW);
        i_smp = 1'b0;
        i_ld  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_smp = 1'b0; i_ld = 1'b0; i_acc = '0; i_w_init = '0;
        pSmp = 1'b0; pLd = 1'b0; pAcc = 32'hFF00_0000; pWInit = '0;

        tick();
        tick();
        checkOutput("rst.w",      o_w, 32'h0);
        checkOutput("rst.busy",   {31'b0, o_busy}, 32'd0);
        checkOutput("rst.done",   {31'b0, o_done}, 32'd0);
        checkOutput("rst.accClr", {31'b0, o_acc_clr}, 32'd0);
        checkOutput("rst.sat",    {31'b0, o_sat}, 32'd0);
        checkOutput("rst.psW",    pW, 32'h0);
        rst = 1'b0;

        // Normal batch: 1.0 - 0.25/4 = 0.9375
        applyStimulus(1'b1, 1'b0, 32'h0100_0000, 32'h0);
        checkOutput("norm.load", o_w, 32'h0100_0000);
        doBatch("norm", 32'h0100_0000, 32'h0040_0000, 32'h00F0_0000, 1'b0, 1'b0);

        // Samples and loads while busy are dropped; next batch needs 4 fresh pulses
        doBatch("hold",  32'h00F0_0000, 32'h0040_0000, 32'h00E0_0000, 1'b0, 1'b1);
        doBatch("fresh", 32'h00E0_0000, 32'h0040_0000, 32'h00D0_0000, 1'b0, 1'b0);

        // Load wins over a coincident sample and restarts the count
        applyStimulus(1'b1, 1'b0, 32'h0100_0000, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h0200_0000, 32'h0);
        checkOutput("prio.w",    o_w, 32'h0200_0000);
        checkOutput("prio.busy", {31'b0, o_busy}, 32'd0);
        doBatch("prio", 32'h0200_0000, 32'h0080_0000, 32'h01E0_0000, 1'b0, 1'b0);

        // Negative clamp: -128.0 - 1.0 saturates at the minimum
        applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'h0);
        doBatch("negSat", 32'h8000_0000, 32'h0400_0000, 32'h8000_0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
        checkOutput("negSat.stickyOnLoad", {31'b0, o_sat}, 32'd1);

        // Reset during APPLY: no write, no done pulse, sat flag cleared
        applyStimulus(1'b1, 1'b0, 32'h0100_0000, 32'h0);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
        checkOutput("rstMid.inApply", {31'b0, o_acc_clr}, 32'd1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0040_0000);
        checkOutput("rstMid.w",      o_w, 32'h0);
        checkOutput("rstMid.done",   {31'b0, o_done}, 32'd0);
        checkOutput("rstMid.busy",   {31'b0, o_busy}, 32'd0);
        checkOutput("rstMid.accClr", {31'b0, o_acc_clr}, 32'd0);
        checkOutput("rstMid.sat",    {31'b0, o_sat}, 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("rstMid.noDone", {31'b0, o_done}, 32'd0);
        checkOutput("rstMid.idle",   {31'b0, o_busy}, 32'd0);

        // Positive clamp: 127.0 - (-32.0) saturates; flag survives a normal batch
        applyStimulus(1'b1, 1'b0, 32'h7F00_0000, 32'h0);
        doBatch("posSat",   32'h7F00_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
        doBatch("afterSat", 32'h7FFF_FFFF, 32'h0040_0000, 32'h7FEF_FFFF, 1'b1, 1'b0);

        // Per-sample mode: each pulse adds 1.0 (acc = -1.0, no scaling)
        for (int k = 0; k < 2; k++) begin
            pSmp = 1'b1;
            tick();
            pSmp = 1'b0;
            checkOutput($sformatf("ps%0d.accClr", k), {31'b0, pAccClr}, 32'd1);
            checkOutput($sformatf("ps%0d.oldW", k), pW, 32'h0100_0000 * k);
            tick();
            checkOutput($sformatf("ps%0d.done", k), {31'b0, pDone}, 32'd1);
            checkOutput($sformatf("ps%0d.w", k), pW, 32'h0100_0000 * (k + 1));
            tick();
            checkOutput($sformatf("ps%0d.idle", k), {31'b0, pBusy}, 32'd0);
        end
        checkOutput("ps.sat", {31'b0, pSat}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule

// File: doc/wght_upd.md
Name: wght_upd

Overview:
- Weight update stage directly downstream of the weight accumulator.
- Counts accumulated samples over a mini-batch of 2^LOG2_BATCH samples.
- At batch end: reads the accumulated gradient, scales it by the batch size (arithmetic shift), and applies w <= sat(w - scaled_acc) to the stored weight in Q(WIDTH-FRAC).FRAC fixed point.
- Clears the accumulator and signals completion to the layer controller.

Parameters:
- WIDTH, 32, data word width (signed, two's complement).
- FRAC, 24, fractional bits (Q8.24 at defaults).
- LOG2_BATCH, 2, log2 of batch size; 0 means per-sample update with no scaling.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_smp  in  1  one-cycle pulse, coincident with the accumulator's en: one sample accumulated.
- i_acc  in  WIDTH  accumulator output (the accumulator's registered sum).
- i_ld  in  1  load initial weight.
- i_w_init  in  WIDTH  initial weight value.
- o_w  out  WIDTH  current weight (registered).
- o_acc_clr  out  1  clear to the accumulator; asserted exactly during the APPLY cycle.
- o_busy  out  1  high in APPLY and DONE; upstream must hold en low while high.
- o_done  out  1  one-cycle pulse: new weight valid on o_w.
- o_sat  out  1  sticky saturation flag.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: o_w=0, o_sat=0, o_done=0, o_busy=0, o_acc_clr=0, sample count=0, state=ACC.
- States:
  - ACC: counting samples.
  - APPLY: one cycle, weight write.
  - DONE: one cycle, pulse o_done.
  - Then back to ACC.
- ACC state, priority rst > i_ld > i_smp:
  - i_ld: o_w <= i_w_init, count <= 0, o_sat unchanged, stay in ACC.
  - i_smp with count < 2^LOG2_BATCH-1: count++.
  - i_smp with count == 2^LOG2_BATCH-1: count <= 0, go to APPLY.
- APPLY (cycle t+1 after the last sample at t):
  - i_acc holds the final sum in this cycle.
  - scaled = i_acc >>> LOG2_BATCH (arithmetic, truncation toward -inf).
  - diff = sext(o_w) - sext(scaled), computed at WIDTH+1 bits.
  - Saturate to [0x7FFF_FFFF, 0x8000_0000] (parameterised by WIDTH); o_w <= result at end of t+1.
  - If saturation occurred, o_sat <= 1.
  - o_acc_clr = 1, decoded from state, so the accumulator clears on the same edge the weight is written.
- DONE (cycle t+2): o_done = 1; o_w shows the new weight.
- o_busy = (state==APPLY) || (state==DONE).
- i_smp or i_ld while busy: ignored; not counted, no load.
- Latency: last sample pulse to o_done = 2 cycles; o_w updates 1 cycle before o_done.
- Reset mid-APPLY or mid-DONE: state returns to ACC and all outputs take reset values; no partial write is possible because the weight is written on a single edge.
- o_sat clears only on rst.

Decomposition:
- Shared package: FRAC default, state encoding (ACC, APPLY, DONE), and a function for signed max/min by WIDTH.
- One sub-module: sat_sub, a combinational WIDTH-bit saturating subtractor with a sat flag output.
- Counter and FSM stay in wght_upd.

Test Plan:
- Reset: assert rst 2 cycles -> o_w=0, o_busy=0, o_done=0, o_acc_clr=0, o_sat=0.
- Normal batch:
  - Stimulus: i_ld with i_w_init=0x0100_0000 (1.0); 4 i_smp pulses; i_acc=0x0040_0000 (0.25) in the APPLY cycle.
  - Response: o_acc_clr high exactly 1 cycle after the 4th pulse; o_w=0x00F0_0000 (0.9375) thereafter; o_done high the next cycle; o_sat=0.
- Saturation:
  - Stimulus: o_w=0x7F00_0000, i_acc=0x8000_0000; scaled = 0xE000_0000 (-32.0).
  - Response: o_w=0x7FFF_FFFF, o_sat=1 and stays 1 through a following normal batch.
- Busy drop: i_smp pulsed during the APPLY and DONE cycles -> count remains 0; the next update still needs 4 fresh pulses.
- Priority: i_ld and i_smp in the same ACC cycle with count=2 -> o_w=i_w_init, count=0; 4 more pulses are required.
- Reset mid-operation: rst during APPLY -> o_w=0 next cycle, no o_done pulse, state ACC.
- Per-sample mode: LOG2_BATCH=0, o_w=0, i_acc=0xFF00_0000 (-1.0) -> o_w=0x0100_0000 two cycles after each i_smp.
